// File: rtl/clk_div_frac.sv
// -----------------------------------------------------------------------------
// clk_div_frac
//   Fractional clock / tick generator. Each half period of clk_out lasts a
//   programmable integer number of clk cycles, and is stretched by one cycle
//   whenever the fractional phase accumulator overflows. This gives an average
//   half period of int + frac/2^FRAC_W clk cycles. A one-cycle tick strobe
//   marks every clk_out rising edge.
//
//   Starting and stopping are glitch-free: a stop request always lets the
//   current high phase finish. A new divisor is held as pending and only
//   takes effect on a period boundary (the clk_out 0->1 edge), or at once
//   when the block is idle.
//
// Ports
//   clk       in   board clock
//   rst_n     in   asynchronous active-low reset
//   en        in   run request (level)
//   div_int   in   [CNT_W-1:0]  new integer half period, sampled when load=1
//   div_frac  in   [FRAC_W-1:0] new fractional half period, sampled when load=1
//   load      in   one-cycle request to take div_int/div_frac
//   load_ack  out  one-cycle pulse when the new divisor becomes active
//   clk_out   out  divided clock, registered, ~50% duty
//   tick      out  one-cycle strobe coincident with the clk_out 0->1 update
//   running   out  high while the FSM is not IDLE
// -----------------------------------------------------------------------------
module clk_div_frac #(
  parameter int                CNT_W        = 16,
  parameter int                FRAC_W       = 8,
  parameter logic [CNT_W-1:0]  DIV_DEFAULT  = CNT_W'(1525),
  parameter logic [FRAC_W-1:0] FRAC_DEFAULT = FRAC_W'(225)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              load,
  output logic              load_ack,
  output logic              clk_out,
  output logic              tick,
  output logic              running
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_t;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [FRAC_W-1:0]   acc_q,       acc_d;
  logic                carry_q,     carry_d;
  logic                clk_out_q,   clk_out_d;
  logic                tick_q,      tick_d;
  logic                load_ack_q,  load_ack_d;
  logic                running_q,   running_d;
  logic [CNT_W-1:0]    act_int_q,   act_int_d;
  logic [FRAC_W-1:0]   act_frac_q,  act_frac_d;
  logic [CNT_W-1:0]    pend_int_q,  pend_int_d;
  logic [FRAC_W-1:0]   pend_frac_q, pend_frac_d;
  logic                pend_q,      pend_d;

  logic [CNT_W-1:0]    eff_int;
  logic [CNT_W-1:0]    h_last;
  logic                terminal;
  logic                apply;
  logic [FRAC_W:0]     frac_sum;

  // Integer half periods below 2 would give clk_out periods under 4 clk.
  assign eff_int = (act_int_q < CNT_W'(2)) ? CNT_W'(2) : act_int_q;

  // Last count value of this half period. A carry from the previous toggle
  // lengthens it by one, except at the top of the range, where the extra
  // cycle is dropped so the counter never wraps.
  assign h_last = (carry_q && (eff_int != {CNT_W{1'b1}})) ? eff_int
                                                          : eff_int - CNT_W'(1);

  assign terminal = (state_q != S_IDLE) && (cnt_q == h_last);
  assign frac_sum = {1'b0, acc_q} + {1'b0, act_frac_q};

  // A divisor is waiting, or is being offered this very cycle.
  assign apply = load || pend_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    clk_out_d   = clk_out_q;
    tick_d      = 1'b0;
    load_ack_d  = 1'b0;
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    pend_d      = pend_q;

    // Capture into pending; a later load before the boundary overwrites it.
    if (load) begin
      pend_int_d  = div_int;
      pend_frac_d = div_frac;
      pend_d      = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        acc_d     = '0;
        carry_d   = 1'b0;
        clk_out_d = 1'b0;
        // Nothing is running, so a new divisor can take effect at once.
        if (apply) begin
          act_int_d  = load ? div_int  : pend_int_q;
          act_frac_d = load ? div_frac : pend_frac_q;
          pend_d     = 1'b0;
          load_ack_d = 1'b1;
        end
        if (en) state_d = S_RUN;
      end

      default: begin  // S_RUN, S_STOP: both keep counting
        if (terminal) begin
          cnt_d              = '0;
          clk_out_d          = ~clk_out_q;
          {carry_d, acc_d}   = frac_sum;
          if (!clk_out_q) begin
            // Rising edge: a period boundary, the only safe point to reload.
            tick_d = 1'b1;
            if (apply) begin
              act_int_d  = load ? div_int  : pend_int_q;
              act_frac_d = load ? div_frac : pend_frac_q;
              acc_d      = '0;
              carry_d    = 1'b0;
              pend_d     = 1'b0;
              load_ack_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_q == S_RUN) begin
          if (!en) state_d = S_STOP;
        end else if (en) begin
          state_d = S_RUN;
        end else if (terminal && clk_out_q) begin
          // High phase has just completed; park with clk_out low.
          state_d = S_IDLE;
          acc_d   = '0;
          carry_d = 1'b0;
        end
      end
    endcase

    running_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      load_ack_q  <= 1'b0;
      running_q   <= 1'b0;
      act_int_q   <= DIV_DEFAULT;
      act_frac_q  <= FRAC_DEFAULT;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values
      // from before this edge regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      load_ack_q  <= load_ack_d;
      running_q   <= running_d;
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      pend_q      <= pend_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign load_ack = load_ack_q;
  assign running  = running_q;

endmodule
